// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response encoding for the AXI-Lite slave endpoints.
package axi_lite_pkg;

   typedef logic [1:0] axi_resp_t;

   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_wr_join.sv
// AXI-Lite write channel join: holds AW and W independently, commits once both are present,
// then owns the B handshake until the master accepts the response.
module axi_lite_wr_join
   import axi_lite_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_valid,
   output logic                    w_ready,
   output axi_resp_t               b_resp,
   output logic                    b_valid,
   input  logic                    b_ready,
   output logic                    commit,
   output logic [ADDR_WIDTH-1:0]   commit_addr,
   output logic [DATA_WIDTH-1:0]   commit_data,
   output logic [DATA_WIDTH/8-1:0] commit_strb,
   input  axi_resp_t               commit_resp
);

   logic                    aw_held_q;
   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic                    w_held_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [DATA_WIDTH/8-1:0] w_strb_q;
   logic                    b_valid_q;
   axi_resp_t               b_resp_q;
   logic                    aw_hs;
   logic                    w_hs;

   // Readies depend only on state, so there is no valid-to-ready combinational path.
   assign aw_ready = !aw_held_q && !b_valid_q;
   assign w_ready  = !w_held_q && !b_valid_q;
   assign aw_hs    = aw_valid && aw_ready;
   assign w_hs     = w_valid && w_ready;

   assign commit      = (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign commit_addr = aw_held_q ? aw_addr_q : aw_addr;
   assign commit_data = w_held_q ? w_data_q : w_data;
   assign commit_strb = w_held_q ? w_strb_q : w_strb;

   assign b_valid = b_valid_q;
   assign b_resp  = b_resp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held_q <= 1'b0;
         aw_addr_q <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_valid_q <= 1'b0;
         b_resp_q  <= RESP_OKAY;
      end else if (commit) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         b_valid_q <= 1'b1;
         b_resp_q  <= commit_resp;
      end else begin
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_addr_q <= aw_addr;
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= w_data;
            w_strb_q <= w_strb;
         end
         if (b_valid_q && b_ready) begin
            b_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/axi_lite_regfile.sv
// Generic AXI-Lite control/status register file with per-word RO/RW selection,
// byte-strobed writes, write pulses to fabric and SLVERR on bad targets.
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            DATA_WIDTH = 32,
   parameter int unsigned            NUM_REGS   = 16,
   parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
   parameter logic [DATA_WIDTH-1:0]  RESET_VAL  = '0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [ADDR_WIDTH-1:0]          aw_addr,
   input  logic                           aw_valid,
   output logic                           aw_ready,
   input  logic [DATA_WIDTH-1:0]          w_data,
   input  logic [DATA_WIDTH/8-1:0]        w_strb,
   input  logic                           w_valid,
   output logic                           w_ready,
   output logic [1:0]                     b_resp,
   output logic                           b_valid,
   input  logic                           b_ready,
   input  logic [ADDR_WIDTH-1:0]          ar_addr,
   input  logic                           ar_valid,
   output logic                           ar_ready,
   output logic [DATA_WIDTH-1:0]          r_data,
   output logic [1:0]                     r_resp,
   output logic                           r_valid,
   input  logic                           r_ready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_i,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned LSB        = $clog2(STRB_WIDTH);
   localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - LSB;

   logic                  commit;
   logic [ADDR_WIDTH-1:0] commit_addr;
   logic [DATA_WIDTH-1:0] commit_data;
   logic [STRB_WIDTH-1:0] commit_strb;
   axi_resp_t             commit_resp;

   logic [IDX_WIDTH-1:0]  wr_idx;
   logic [IDX_WIDTH-1:0]  rd_idx;
   logic [NUM_REGS-1:0]   wr_hit;
   logic                  wr_ok;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  rd_ok;
   logic                  unused_addr_bits;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]   wr_pulse_q;
   logic                  r_valid_q;
   logic [DATA_WIDTH-1:0] r_data_q;
   axi_resp_t             r_resp_q;

   axi_lite_wr_join #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_wr_join (
      .clk         (clk),
      .rst         (rst),
      .aw_addr     (aw_addr),
      .aw_valid    (aw_valid),
      .aw_ready    (aw_ready),
      .w_data      (w_data),
      .w_strb      (w_strb),
      .w_valid     (w_valid),
      .w_ready     (w_ready),
      .b_resp      (b_resp),
      .b_valid     (b_valid),
      .b_ready     (b_ready),
      .commit      (commit),
      .commit_addr (commit_addr),
      .commit_data (commit_data),
      .commit_strb (commit_strb),
      .commit_resp (commit_resp)
   );

   assign wr_idx = commit_addr[ADDR_WIDTH-1:LSB];
   assign rd_idx = ar_addr[ADDR_WIDTH-1:LSB];
   assign unused_addr_bits = ^{commit_addr[LSB-1:0], ar_addr[LSB-1:0]};

   // Write target decode: only in-range RW words are writable.
   always_comb begin
      wr_hit = '0;
      wr_ok  = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_idx == IDX_WIDTH'(i) && !RO_MASK[i]) begin
            wr_hit[i] = 1'b1;
            wr_ok     = 1'b1;
         end
      end
      commit_resp = wr_ok ? RESP_OKAY : RESP_SLVERR;
   end

   always_comb begin
      rd_word = '0;
      rd_ok   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_WIDTH'(i)) begin
            rd_ok   = 1'b1;
            rd_word = RO_MASK[i] ? hw_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q     <= '{default: RESET_VAL};
         wr_pulse_q <= '0;
      end else begin
         wr_pulse_q <= commit ? wr_hit : '0;
         if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               for (int b = 0; b < STRB_WIDTH; b++) begin
                  if (wr_hit[i] && commit_strb[b]) begin
                     regs_q[i][8*b +: 8] <= commit_data[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Read captures regs_q before any same-cycle commit lands, so it sees the old value.
   assign ar_ready = !r_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
         r_resp_q  <= RESP_OKAY;
      end else if (ar_valid && ar_ready) begin
         r_valid_q <= 1'b1;
         r_data_q  <= rd_word;
         r_resp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (r_valid_q && r_ready) begin
         r_valid_q <= 1'b0;
      end
   end

   assign r_valid    = r_valid_q;
   assign r_data     = r_data_q;
   assign r_resp     = r_resp_q;
   assign wr_pulse_o = wr_pulse_q;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
      assign reg_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
   end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: 32-bit, 16 words, word 15 read-only.
module tb_axi_lite_regfile;

   logic         clk;
   logic         rst;
   logic [31:0]  aw_addr;
   logic         aw_valid;
   logic         aw_ready;
   logic [31:0]  w_data;
   logic [3:0]   w_strb;
   logic         w_valid;
   logic         w_ready;
   logic [1:0]   b_resp;
   logic         b_valid;
   logic         b_ready;
   logic [31:0]  ar_addr;
   logic         ar_valid;
   logic         ar_ready;
   logic [31:0]  r_data;
   logic [1:0]   r_resp;
   logic         r_valid;
   logic         r_ready;
   logic [511:0] reg_o;
   logic [511:0] hw_i;
   logic [15:0]  wr_pulse_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic [511:0] exp_regs;
   logic [31:0]  rd;
   logic [1:0]   rs;
   logic [15:0]  pl;
   int           cnt;

   axi_lite_regfile #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .NUM_REGS  (16),
      .RO_MASK   (16'h8000),
      .RESET_VAL (32'h0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .aw_addr    (aw_addr),
      .aw_valid   (aw_valid),
      .aw_ready   (aw_ready),
      .w_data     (w_data),
      .w_strb     (w_strb),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .b_resp     (b_resp),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .ar_addr    (ar_addr),
      .ar_valid   (ar_valid),
      .ar_ready   (ar_ready),
      .r_data     (r_data),
      .r_resp     (r_resp),
      .r_valid    (r_valid),
      .r_ready    (r_ready),
      .reg_o      (reg_o),
      .hw_i       (hw_i),
      .wr_pulse_o (wr_pulse_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Entered and left at #1 after a rising edge.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output logic [15:0] pulse);
      int n;
      aw_addr = addr; w_data = data; w_strb = strb;
      aw_valid = 1'b1; w_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(aw_ready && w_ready) && n < 20) begin @(negedge clk); n++; end
      check_eq("wr_accept", {aw_ready, w_ready}, 2'b11);
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!b_valid && n < 20) begin @(negedge clk); n++; end
      check_eq("wr_bvalid", b_valid, 1'b1);
      resp  = b_resp;
      pulse = wr_pulse_o;
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      int n;
      ar_addr = addr; ar_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ar_ready && n < 20) begin @(negedge clk); n++; end
      check_eq("rd_accept", ar_ready, 1'b1);
      @(posedge clk); #1;
      ar_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!r_valid && n < 20) begin @(negedge clk); n++; end
      check_eq("rd_rvalid", r_valid, 1'b1);
      data = r_data;
      resp = r_resp;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      aw_addr = '0; aw_valid = 1'b0; w_data = '0; w_strb = '0; w_valid = 1'b0;
      ar_addr = '0; ar_valid = 1'b0; b_ready = 1'b1; r_ready = 1'b1;
      hw_i = '0;
      hw_i[15*32 +: 32] = 32'hCAFE0001;
      exp_regs = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check_eq("rst_ready", {aw_ready, w_ready, ar_ready}, 3'b111);
      check_eq("rst_valid", {b_valid, r_valid}, 2'b00);
      check_eq("rst_resp", {b_resp, r_resp}, 4'b0000);
      check_eq("rst_rdata", r_data, 32'h0);
      check_eq("rst_pulse", wr_pulse_o, 16'h0);
      check_eq("rst_regs", reg_o, exp_regs);

      // AW+W same cycle to 0x04
      @(posedge clk); #1;
      aw_addr = 32'h04; w_data = 32'hDEADBEEF; w_strb = 4'hF;
      aw_valid = 1'b1; w_valid = 1'b1;
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      @(negedge clk);
      exp_regs[1*32 +: 32] = 32'hDEADBEEF;
      check_eq("w1_bvalid", b_valid, 1'b1);
      check_eq("w1_bresp", b_resp, 2'b00);
      check_eq("w1_pulse", wr_pulse_o, 16'h0002);
      check_eq("w1_regs", reg_o, exp_regs);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("w1_bdone", b_valid, 1'b0);
      check_eq("w1_pulse_end", wr_pulse_o, 16'h0000);
      @(posedge clk); #1;
      axi_read(32'h04, rd, rs);
      check_eq("r1_data", rd, 32'hDEADBEEF);
      check_eq("r1_resp", rs, 2'b00);

      // W three cycles ahead of AW, partial strobe
      w_data = 32'h11223344; w_strb = 4'b0101; w_valid = 1'b1;
      @(posedge clk); #1;
      w_valid = 1'b0;
      @(negedge clk);
      check_eq("w2_held_rdy", {aw_ready, w_ready, b_valid}, 3'b100);
      repeat (2) @(posedge clk);
      #1;
      aw_addr = 32'h08; aw_valid = 1'b1;
      @(posedge clk); #1;
      aw_valid = 1'b0;
      @(negedge clk);
      exp_regs[2*32 +: 32] = 32'h00220044;
      check_eq("w2_bvalid", {b_valid, b_resp}, 3'b100);
      check_eq("w2_pulse", wr_pulse_o, 16'h0004);
      @(posedge clk); #1;
      axi_read(32'h08, rd, rs);
      check_eq("r2_data", rd, 32'h00220044);

      // Out-of-range index 16
      axi_write(32'h40, 32'h55555555, 4'hF, rs, pl);
      check_eq("w_oor_resp", rs, 2'b10);
      check_eq("w_oor_pulse", pl, 16'h0);
      check_eq("w_oor_regs", reg_o, exp_regs);
      axi_read(32'h40, rd, rs);
      check_eq("r_oor_data", rd, 32'h0);
      check_eq("r_oor_resp", rs, 2'b10);

      // Read-only word 15
      axi_write(32'h3C, 32'h12121212, 4'hF, rs, pl);
      check_eq("w_ro_resp", rs, 2'b10);
      check_eq("w_ro_pulse", pl, 16'h0);
      check_eq("w_ro_regs", reg_o, exp_regs);
      axi_read(32'h3C, rd, rs);
      check_eq("r_ro_data", rd, 32'hCAFE0001);
      check_eq("r_ro_resp", rs, 2'b00);

      // All-zero strobe: OKAY and pulse, value unchanged
      axi_write(32'h10, 32'hFFFFFFFF, 4'h0, rs, pl);
      check_eq("w_zs_resp", rs, 2'b00);
      check_eq("w_zs_pulse", pl, 16'h0010);
      check_eq("w_zs_regs", reg_o, exp_regs);

      // Same-cycle read and write of word 1: read sees old value
      aw_addr = 32'h04; w_data = 32'h12345678; w_strb = 4'hF;
      aw_valid = 1'b1; w_valid = 1'b1;
      ar_addr = 32'h04; ar_valid = 1'b1;
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      @(negedge clk);
      exp_regs[1*32 +: 32] = 32'h12345678;
      check_eq("rw_rdata", {r_valid, r_data}, {1'b1, 32'hDEADBEEF});
      check_eq("rw_bvalid", {b_valid, b_resp}, 3'b100);
      @(posedge clk); #1;
      check_eq("rw_regs", reg_o, exp_regs);

      // B back-pressure for more than 10 cycles with a read in between
      b_ready = 1'b0;
      aw_addr = 32'h0C; w_data = 32'hA5A5A5A5; w_strb = 4'hF;
      aw_valid = 1'b1; w_valid = 1'b1;
      @(posedge clk); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("bs_hold_a", {b_valid, aw_ready, w_ready}, 3'b100);
         @(posedge clk); #1;
      end
      axi_read(32'h04, rd, rs);
      check_eq("bs_rd_data", rd, 32'h12345678);
      check_eq("bs_rd_resp", rs, 2'b00);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("bs_hold_b", {b_valid, aw_ready, w_ready}, 3'b100);
         @(posedge clk); #1;
      end
      b_ready = 1'b1;
      @(negedge clk);
      check_eq("bs_release", {b_valid, b_resp}, 3'b100);
      @(posedge clk); #1;
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (b_valid) cnt++;
      end
      check_eq("bs_single_b", cnt, 0);
      @(posedge clk); #1;
      exp_regs[3*32 +: 32] = 32'hA5A5A5A5;
      axi_read(32'h0C, rd, rs);
      check_eq("bs_wr_data", rd, 32'hA5A5A5A5);

      // Reset with AW held and R pending
      r_ready = 1'b0;
      aw_addr = 32'h14; aw_valid = 1'b1;
      ar_addr = 32'h04; ar_valid = 1'b1;
      @(posedge clk); #1;
      aw_valid = 1'b0; ar_valid = 1'b0;
      @(negedge clk);
      check_eq("pre_rst", {r_valid, aw_ready, w_ready, ar_ready}, 4'b1010);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      exp_regs = '0;
      check_eq("mid_rst_valid", {b_valid, r_valid}, 2'b00);
      check_eq("mid_rst_ready", {aw_ready, w_ready, ar_ready}, 3'b111);
      check_eq("mid_rst_regs", reg_o, exp_regs);
      check_eq("mid_rst_rdata", r_data, 32'h0);
      r_ready = 1'b1;
      @(posedge clk); #1;
      w_data = 32'h99999999; w_strb = 4'hF; w_valid = 1'b1;
      @(posedge clk); #1;
      w_valid = 1'b0;
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (b_valid || r_valid || (wr_pulse_o != 16'h0)) cnt++;
      end
      check_eq("post_rst_quiet", cnt, 0);
      check_eq("post_rst_regs", reg_o, exp_regs);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
